// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR: one sample in through valid/ready, then one multiply-accumulate per clock
// over a circular sample history. The full-precision result comes out with a one-cycle strobe.
module fir_serial_mac #(
  parameter int WIDTH = 7,
  parameter int TAPS  = 33,
  parameter int ACC_W = 2*WIDTH+6
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    din_valid,
  input  logic signed [WIDTH-1:0] din,
  output logic                    din_ready,
  input  logic                    coef_we,
  input  logic [5:0]              coef_addr,
  input  logic signed [WIDTH-1:0] coef_data,
  output logic                    dout_valid,
  output logic signed [ACC_W-1:0] dout,
  output logic                    busy
);
  localparam int PTR_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PROD_W = 2*WIDTH;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(TAPS-1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                  r_state;
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [PTR_W-1:0]        r_k;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_dout;
  logic                    r_dout_valid;
  logic                    r_busy;
  logic                    r_din_ready;
  logic signed [WIDTH-1:0] r_hist [TAPS];
  logic signed [WIDTH-1:0] r_coef [TAPS];

  logic                     w_hs;
  logic                     w_coef_wr;
  logic [PTR_W-1:0]         w_coef_idx;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;

  assign w_hs       = din_valid && r_din_ready;
  assign w_coef_wr  = coef_we && (r_state == IDLE) && (32'(coef_addr) < TAPS);
  assign w_coef_idx = PTR_W'(coef_addr);
  assign w_prod     = r_coef[r_k] * r_hist[r_rd_ptr];
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

  // Storage is cleared by reset so outputs before TAPS samples are the zero-padded convolution.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < TAPS; i++) begin
        r_hist[i] <= '0;
        r_coef[i] <= '0;
      end
    end else begin
      if (w_hs)
        r_hist[r_wr_ptr] <= din;
      if (w_coef_wr)
        r_coef[w_coef_idx] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_k          <= '0;
      r_acc        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_din_ready  <= 1'b1;
    end else begin
      r_dout_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_rd_ptr    <= r_wr_ptr;
            r_k         <= '0;
            r_acc       <= '0;
            r_busy      <= 1'b1;
            r_din_ready <= 1'b0;
            r_state     <= MAC;
          end
        end
        MAC: begin
          // Walk backwards through history so tap k multiplies x[n-k].
          r_acc    <= r_acc + w_prod_ext;
          r_k      <= r_k + 1'b1;
          r_rd_ptr <= (r_rd_ptr == '0) ? LAST : r_rd_ptr - 1'b1;
          if (r_k == LAST)
            r_state <= DONE;
        end
        DONE: begin
          r_dout       <= r_acc;
          r_dout_valid <= 1'b1;
          r_wr_ptr     <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
          r_busy       <= 1'b0;
          r_din_ready  <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign din_ready  = r_din_ready;
  assign dout_valid = r_dout_valid;
  assign dout       = r_dout;
  assign busy       = r_busy;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Directed bench for fir_serial_mac: impulse, worst-case magnitude, back-to-back streaming,
// coefficient write gating, reset mid-MAC and simultaneous write/handshake.
module tb_fir_serial_mac;
  localparam int W  = 7;
  localparam int T  = 33;
  localparam int AW = 2*W+6;
  localparam int LAT = T+1;
  localparam int NB  = 40;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 din_valid;
  logic signed [W-1:0]  din;
  logic                 din_ready;
  logic                 coef_we;
  logic [5:0]           coef_addr;
  logic signed [W-1:0]  coef_data;
  logic                 dout_valid;
  logic signed [AW-1:0] dout;
  logic                 busy;

  int n_checks;
  int n_fail;
  int bt_c [T];
  int bt_x [NB];

  fir_serial_mac #(.WIDTH(W), .TAPS(T), .ACC_W(AW)) dut (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .dout_valid(dout_valid), .dout(dout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    din_valid = 1'b0;
    coef_we   = 1'b0;
    rstn      = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic write_coef(input int addr, input int data);
    coef_we   = 1'b1;
    coef_addr = 6'(addr);
    coef_data = W'(data);
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic wait_result(output logic signed [AW-1:0] y, output int lat, output bit ok);
    lat = 0;
    while (!dout_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    ok = dout_valid;
    y  = dout;
  endtask

  task automatic send_sample(input int d, output logic signed [AW-1:0] y, output int lat, output bit ok);
    int t;
    t = 0;
    while (!din_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    din       = W'(d);
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    wait_result(y, lat, ok);
  endtask

  function automatic int model_y(int n);
    int s;
    s = 0;
    for (int k = 0; k < T; k++)
      if (n - k >= 0) s += bt_c[k] * bt_x[n-k];
    return s;
  endfunction

  task automatic test_reset();
    rstn = 1'b1; din_valid = 1'b0; coef_we = 1'b0; din = '0; coef_addr = '0; coef_data = '0;
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %0d expected 0", dout); end
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid: got %b expected 0", dout_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rstn = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL reset_din_ready: got %b expected 1", din_ready); end
    $display("test_reset done");
  endtask

  task automatic test_impulse();
    logic signed [AW-1:0] y;
    int lat;
    bit ok;
    apply_reset();
    for (int k = 0; k < T; k++) write_coef(k, k+1);
    for (int n = 0; n <= T; n++) begin
      send_sample((n == 0) ? 1 : 0, y, lat, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL impulse_timeout[%0d]: got no dout_valid expected strobe", n); end
      else begin
        if (y !== AW'((n < T) ? n+1 : 0)) begin n_fail++; $display("FAIL impulse_y[%0d]: got %0d expected %0d", n, y, (n < T) ? n+1 : 0); end
        n_checks++;
        if (lat != LAT) begin n_fail++; $display("FAIL impulse_latency[%0d]: got %0d expected %0d", n, lat, LAT); end
      end
      @(posedge clk); #1;
      n_checks++;
      if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL impulse_pulse[%0d]: got dout_valid %b expected 0", n, dout_valid); end
      $display("impulse n=%0d dout=%0d", n, y);
    end
  endtask

  task automatic test_worst_case();
    logic signed [AW-1:0] y;
    int lat;
    bit ok;
    apply_reset();
    for (int k = 0; k < T; k++) write_coef(k, -64);
    for (int n = 0; n < T; n++) begin
      send_sample(-64, y, lat, ok);
      n_checks++;
      if (!ok || y !== AW'((n+1)*4096)) begin n_fail++; $display("FAIL worst_y[%0d]: got %0d expected %0d", n, y, (n+1)*4096); end
    end
    $display("worst 33rd dout=%0d", y);
    send_sample(63, y, lat, ok);
    n_checks++;
    if (!ok || y !== AW'(127040)) begin n_fail++; $display("FAIL worst_mixed: got %0d expected 127040", y); end
    $display("worst mixed dout=%0d", y);
  endtask

  task automatic test_back_to_back();
    int acc_edge [NB];
    int edge_cnt, idx, n_out;
    bit rdy;
    apply_reset();
    for (int k = 0; k < T; k++) begin bt_c[k] = k - 16; write_coef(k, bt_c[k]); end
    for (int i = 0; i < NB; i++) bt_x[i] = ((i*7) % 23) - 11;
    edge_cnt = 0; idx = 0; n_out = 0;
    din = W'(bt_x[0]);
    din_valid = 1'b1;
    for (int cyc = 0; cyc < NB*(T+2) + 200 && n_out < NB; cyc++) begin
      rdy = din_ready;
      @(posedge clk); #1;
      edge_cnt++;
      if (rdy && din_valid) begin
        acc_edge[idx] = edge_cnt;
        if (idx > 0) begin
          n_checks++;
          if (edge_cnt - acc_edge[idx-1] != T+2) begin n_fail++; $display("FAIL b2b_interval[%0d]: got %0d expected %0d", idx, edge_cnt - acc_edge[idx-1], T+2); end
        end
        idx++;
        if (idx < NB) din = W'(bt_x[idx]);
        else din_valid = 1'b0;
      end
      if (dout_valid) begin
        n_checks++;
        if (dout !== AW'(model_y(n_out))) begin n_fail++; $display("FAIL b2b_y[%0d]: got %0d expected %0d", n_out, dout, model_y(n_out)); end
        n_checks++;
        if (n_out >= idx || edge_cnt - acc_edge[n_out] != LAT) begin n_fail++; $display("FAIL b2b_latency[%0d]: got edge %0d expected %0d after accept", n_out, edge_cnt, LAT); end
        $display("b2b n=%0d dout=%0d", n_out, dout);
        n_out++;
      end
    end
    din_valid = 1'b0;
    n_checks++;
    if (n_out != NB) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", n_out, NB); end
  endtask

  task automatic test_coef_gating();
    logic signed [AW-1:0] y;
    int lat;
    bit ok;
    apply_reset();
    for (int k = 0; k < T; k++) write_coef(k, k+1);
    write_coef(40, 10);
    din = W'(1);
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    coef_we = 1'b1; coef_addr = 6'd5; coef_data = W'(10);
    wait_result(y, lat, ok);
    coef_we = 1'b0;
    n_checks++;
    if (!ok || y !== AW'(1)) begin n_fail++; $display("FAIL gating_y0: got %0d expected 1", y); end
    for (int n = 1; n <= 7; n++) begin
      send_sample(0, y, lat, ok);
      n_checks++;
      if (!ok || y !== AW'(n+1)) begin n_fail++; $display("FAIL gating_y[%0d]: got %0d expected %0d", n, y, n+1); end
      $display("gating n=%0d dout=%0d", n, y);
    end
  endtask

  task automatic test_reset_mid_mac();
    logic signed [AW-1:0] y;
    int lat;
    bit ok;
    apply_reset();
    write_coef(0, 2);
    write_coef(1, 3);
    send_sample(3, y, lat, ok);
    send_sample(5, y, lat, ok);
    send_sample(6, y, lat, ok);
    n_checks++;
    if (!ok || y !== AW'(27)) begin n_fail++; $display("FAIL rmid_pre: got %0d expected 27", y); end
    din = W'(4);
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b expected 1", busy); end
    rstn = 1'b0;
    #1;
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL rmid_dout: got %0d expected 0", dout); end
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_dout_valid: got %b expected 0", dout_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    #3 rstn = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_din_ready: got %b expected 1", din_ready); end
    write_coef(0, 7);
    send_sample(1, y, lat, ok);
    n_checks++;
    if (!ok || y !== AW'(7)) begin n_fail++; $display("FAIL rmid_impulse: got %0d expected 7", y); end
    $display("rmid impulse dout=%0d", y);
    for (int k = 0; k < T; k++) write_coef(k, 1);
    send_sample(0, y, lat, ok);
    n_checks++;
    if (!ok || y !== AW'(1)) begin n_fail++; $display("FAIL rmid_hist_cleared: got %0d expected 1", y); end
    $display("rmid history sum dout=%0d", y);
  endtask

  task automatic test_simultaneous();
    logic signed [AW-1:0] y;
    int lat;
    bit ok;
    apply_reset();
    coef_we = 1'b1; coef_addr = 6'd0; coef_data = W'(3);
    din = W'(2); din_valid = 1'b1;
    @(posedge clk); #1;
    coef_we = 1'b0; din_valid = 1'b0;
    wait_result(y, lat, ok);
    n_checks++;
    if (!ok || y !== AW'(6)) begin n_fail++; $display("FAIL simul_y: got %0d expected 6", y); end
    $display("simultaneous dout=%0d", y);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_impulse();
    test_worst_case();
    test_back_to_back();
    test_coef_gating();
    test_reset_mid_mac();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
